// File: rtl/opb_cmd_master.sv
// opb_cmd_master: single-outstanding OPB bus master. It turns a ready/valid command
// stream into OPB read/write cycles and returns one response per command.
// Latency: handshake -> REQ -> XFER -> RESP, so 4 cycles per command at best.
// Backpressure: cmd_ready is high only in IDLE. Responses are strobed and cannot be stalled.
// Optional feature: define OPB_CMD_MASTER_RETRY_EN to re-arbitrate on OPB_retry.
// Without it, OPB_retry is treated as OPB_errAck.
//
// Ports:
//   OPB_Clk, OPB_Rst              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_rnw/addr/be/wdata describe the command
//   rsp_valid                     one-cycle response strobe
//   rsp_rdata                     read data, held until the next response
//   rsp_err/rsp_tout              status, held until the next command is accepted
//   M_request/M_select/M_RNW/M_ABus/M_BE/M_DBus/M_seqAddr   master side of the OPB
//   OPB_MGrant/DBus/xferAck/errAck/retry/toutSup             arbiter and slave inputs
// OPB numbers bits big-endian (bit 0 = MSB). Here the vectors are declared [N-1:0], so
// OPB bit 0 maps to bit N-1 and the numeric values are unchanged.
module opb_cmd_master #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = 16,
  parameter int C_MAX_RETRY  = 3
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
  input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
  input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
  output logic                      rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_tout,
  output logic                      M_request,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic [C_OPB_AWIDTH-1:0]   M_ABus,
  output logic [C_OPB_DWIDTH/8-1:0] M_BE,
  output logic [C_OPB_DWIDTH-1:0]   M_DBus,
  output logic                      M_seqAddr,
  input  logic                      OPB_MGrant,
  input  logic [C_OPB_DWIDTH-1:0]   OPB_DBus,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_toutSup
);

  localparam int BW = C_OPB_DWIDTH / 8;
  // The counter checks the last counted cycle, so the abort lands exactly C_TIMEOUT
  // counted XFER cycles after XFER entry.
  localparam logic [7:0] TOUT_LAST = 8'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rnw_q, rnw_d;
  logic [C_OPB_AWIDTH-1:0]   addr_q, addr_d;
  logic [BW-1:0]             be_q, be_d;
  logic [C_OPB_DWIDTH-1:0]   wdata_q, wdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [C_OPB_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_tout_q, rsp_tout_d;
  logic                      m_request_q, m_request_d;
  logic                      m_select_q, m_select_d;
  logic                      m_rnw_q, m_rnw_d;
  logic [C_OPB_AWIDTH-1:0]   m_abus_q, m_abus_d;
  logic [BW-1:0]             m_be_q, m_be_d;
  logic [C_OPB_DWIDTH-1:0]   m_dbus_q, m_dbus_d;
  logic [7:0]                tout_cnt_q, tout_cnt_d;
  logic                      err_term;

`ifdef OPB_CMD_MASTER_RETRY_EN
  localparam logic [7:0] RETRY_MAX = 8'(C_MAX_RETRY);
  logic [7:0] retry_cnt_q, retry_cnt_d;
  assign err_term = OPB_errAck;
`else
  assign err_term = OPB_errAck | OPB_retry;
`endif

  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tout_d  = rsp_tout_q;
    tout_cnt_d  = tout_cnt_q;
`ifdef OPB_CMD_MASTER_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rnw_d      = cmd_rnw;
          addr_d     = cmd_addr;
          be_d       = cmd_be;
          wdata_d    = cmd_wdata;
          rsp_err_d  = 1'b0;
          rsp_tout_d = 1'b0;
`ifdef OPB_CMD_MASTER_RETRY_EN
          retry_cnt_d = '0;
`endif
          state_d    = REQ;
        end
      end
      REQ: begin
        if (OPB_MGrant) begin
          tout_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // Error outranks xferAck. Read data is not captured when both arrive together.
        if (err_term) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (OPB_xferAck) begin
          if (rnw_q) rsp_rdata_d = OPB_DBus;
          state_d = RESP;
`ifdef OPB_CMD_MASTER_RETRY_EN
        end else if (OPB_retry) begin
          if (retry_cnt_q == RETRY_MAX) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            retry_cnt_d = retry_cnt_q + 8'd1;
            state_d     = REQ;
          end
`endif
        end else if (!OPB_toutSup) begin
          if (tout_cnt_q == TOUT_LAST) begin
            rsp_tout_d = 1'b1;
            state_d    = RESP;
          end else begin
            tout_cnt_d = tout_cnt_q + 8'd1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every output is a flop loaded from the next state. The bus is wired-OR, so
    // all M_* lines except M_request are forced to zero outside XFER.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    m_request_d = (state_d == REQ);
    m_select_d  = (state_d == XFER);
    m_rnw_d     = m_select_d & rnw_d;
    m_abus_d    = m_select_d ? addr_d : '0;
    m_be_d      = m_select_d ? be_d : '0;
    m_dbus_d    = (m_select_d && !rnw_d) ? wdata_d : '0;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
      m_request_q <= 1'b0;
      m_select_q  <= 1'b0;
      m_rnw_q     <= 1'b0;
      m_abus_q    <= '0;
      m_be_q      <= '0;
      m_dbus_q    <= '0;
      tout_cnt_q  <= '0;
`ifdef OPB_CMD_MASTER_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tout_q  <= rsp_tout_d;
      m_request_q <= m_request_d;
      m_select_q  <= m_select_d;
      m_rnw_q     <= m_rnw_d;
      m_abus_q    <= m_abus_d;
      m_be_q      <= m_be_d;
      m_dbus_q    <= m_dbus_d;
      tout_cnt_q  <= tout_cnt_d;
`ifdef OPB_CMD_MASTER_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tout  = rsp_tout_q;
  assign M_request = m_request_q;
  assign M_select  = m_select_q;
  assign M_RNW     = m_rnw_q;
  assign M_ABus    = m_abus_q;
  assign M_BE      = m_be_q;
  assign M_DBus    = m_dbus_q;
  assign M_seqAddr = 1'b0;

endmodule
